// File: rtl/alarma_pkg.sv
// -----------------------------------------------------------------------------
// alarma_pkg
// Shared definitions for the alarm command parser and related UART command
// blocks: ASCII character codes, alarm time limits and the parser FSM state
// encoding.
// -----------------------------------------------------------------------------
package alarma_pkg;

   // ASCII character codes
   localparam logic [7:0] CHR_A     = 8'h41;
   localparam logic [7:0] CHR_a     = 8'h61;
   localparam logic [7:0] CHR_X     = 8'h58;
   localparam logic [7:0] CHR_x     = 8'h78;
   localparam logic [7:0] CHR_COLON = 8'h3A;
   localparam logic [7:0] CHR_CR    = 8'h0D;
   localparam logic [7:0] CHR_LF    = 8'h0A;
   localparam logic [7:0] CHR_0     = 8'h30;
   localparam logic [7:0] CHR_9     = 8'h39;

   // Alarm time limits
   localparam logic [4:0] MAX_HOUR = 5'd23;
   localparam logic [5:0] MAX_MIN  = 6'd59;

   // Largest legal tens digit, checked as soon as the tens digit arrives
   localparam logic [3:0] MAX_HOUR_TENS = 4'(MAX_HOUR / 10);
   localparam logic [3:0] MAX_MIN_TENS  = 4'(MAX_MIN / 10);

   // Parser FSM state encoding
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_H_TENS    = 3'd1;
   localparam logic [2:0] ST_H_UNITS   = 3'd2;
   localparam logic [2:0] ST_COLON     = 3'd3;
   localparam logic [2:0] ST_M_TENS    = 3'd4;
   localparam logic [2:0] ST_M_UNITS   = 3'd5;
   localparam logic [2:0] ST_SET_TERM  = 3'd6;
   localparam logic [2:0] ST_STOP_TERM = 3'd7;

endpackage

// File: rtl/ascii_digit_dec.sv
// -----------------------------------------------------------------------------
// ascii_digit_dec
// Combinational ASCII decimal-digit decoder.
//   byte_i     in  8  ASCII byte
//   is_digit_o out 1  byte is '0'..'9'
//   value_o    out 4  digit value (meaningful only when is_digit_o is high)
// -----------------------------------------------------------------------------
module ascii_digit_dec
   import alarma_pkg::*;
(
   input  logic [7:0] byte_i,
   output logic       is_digit_o,
   output logic [3:0] value_o
);

   assign is_digit_o = (byte_i >= CHR_0) && (byte_i <= CHR_9);

   // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
   assign value_o = byte_i[3:0];

endmodule

// File: rtl/alarma_cmd_parser.sv
// -----------------------------------------------------------------------------
// alarma_cmd_parser
// Parses the UART byte stream into alarm-set commands:
//   "A" H H ":" M M CR  -> load strobe with ore_setare/minute_setare
//   "X" CR              -> stop strobe
// Letters are case-insensitive. Malformed commands, out-of-range values and
// inter-byte timeouts produce a cmd_err strobe. All strobes are registered
// and appear one clock after the final byte.
//   clock          in   1  system clock
//   reset          in   1  asynchronous active-low reset
//   rx_data        in   8  received byte
//   rx_valid       in   1  rx_data valid strobe
//   load           out  1  alarm setting valid pulse
//   minute_setare  out  6  alarm minutes 0..59
//   ore_setare     out  5  alarm hours 0..23
//   stop           out  1  silence/clear alarm pulse
//   cmd_err        out  1  command error pulse
//   busy           out  1  command partially received
// -----------------------------------------------------------------------------
module alarma_cmd_parser
   import alarma_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int TO_W           = 26
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       load,
   output logic [5:0] minute_setare,
   output logic [4:0] ore_setare,
   output logic       stop,
   output logic       cmd_err,
   output logic       busy
);

   logic [2:0]      state_q,   state_d;
   logic [4:0]      hour_q,    hour_d;     // hour accumulator
   logic [5:0]      min_q,     min_d;      // minute accumulator
   logic [TO_W-1:0] to_cnt_q,  to_cnt_d;
   logic            load_q,    load_d;
   logic            stop_q,    stop_d;
   logic            err_q,     err_d;
   logic [4:0]      ore_q,     ore_d;
   logic [5:0]      minute_q,  minute_d;

   logic            dig_ok;
   logic [3:0]      dig_val;

   ascii_digit_dec u_dig (
      .byte_i     (rx_data),
      .is_digit_o (dig_ok),
      .value_o    (dig_val)
   );

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      hour_d   = hour_q;
      min_d    = min_q;
      to_cnt_d = to_cnt_q;
      load_d   = 1'b0;
      stop_d   = 1'b0;
      err_d    = 1'b0;
      ore_d    = ore_q;
      minute_d = minute_q;

      if (rx_valid) begin
         // A byte always wins over a timeout expiring in the same cycle.
         to_cnt_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (rx_data == CHR_A || rx_data == CHR_a) begin
                  state_d = ST_H_TENS;
               end else if (rx_data == CHR_X || rx_data == CHR_x) begin
                  state_d = ST_STOP_TERM;
               end else if (rx_data != CHR_CR && rx_data != CHR_LF) begin
                  err_d = 1'b1;
               end
            end
            ST_H_TENS: begin
               if (dig_ok && dig_val <= MAX_HOUR_TENS) begin
                  hour_d  = 5'(dig_val) * 5'd10;
                  state_d = ST_H_UNITS;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_H_UNITS: begin
               if (dig_ok) begin
                  hour_d  = hour_q + 5'(dig_val);
                  state_d = ST_COLON;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_COLON: begin
               if (rx_data == CHR_COLON) begin
                  state_d = ST_M_TENS;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_M_TENS: begin
               if (dig_ok && dig_val <= MAX_MIN_TENS) begin
                  min_d   = 6'(dig_val) * 6'd10;
                  state_d = ST_M_UNITS;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_M_UNITS: begin
               if (dig_ok) begin
                  min_d   = min_q + 6'(dig_val);
                  state_d = ST_SET_TERM;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_SET_TERM: begin
               // Hour tens was limited to 2 on arrival, so 24..29 is caught here.
               if (rx_data == CHR_CR && hour_q <= MAX_HOUR) begin
                  load_d   = 1'b1;
                  ore_d    = hour_q;
                  minute_d = min_q;
               end else begin
                  err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
            ST_STOP_TERM: begin
               if (rx_data == CHR_CR) begin
                  stop_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            err_d    = 1'b1;
            state_d  = ST_IDLE;
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         hour_q   <= '0;
         min_q    <= '0;
         to_cnt_q <= '0;
         load_q   <= 1'b0;
         stop_q   <= 1'b0;
         err_q    <= 1'b0;
         ore_q    <= '0;
         minute_q <= '0;
      end else begin
         state_q  <= state_d;
         hour_q   <= hour_d;
         min_q    <= min_d;
         to_cnt_q <= to_cnt_d;
         load_q   <= load_d;
         stop_q   <= stop_d;
         err_q    <= err_d;
         ore_q    <= ore_d;
         minute_q <= minute_d;
      end
   end

   assign load          = load_q;
   assign stop          = stop_q;
   assign cmd_err       = err_q;
   assign ore_setare    = ore_q;
   assign minute_setare = minute_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alarma_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_alarma_cmd_parser
// Directed self-checking bench for alarma_cmd_parser, run with a 16-cycle
// inter-byte timeout.
// -----------------------------------------------------------------------------
module tb_alarma_cmd_parser;

   localparam int TO = 16;
   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       load;
   logic [5:0] minute_setare;
   logic [4:0] ore_setare;
   logic       stop;
   logic       cmd_err;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   // Strobe totals gathered at every negedge.
   int n_load    = 0;
   int n_stop    = 0;
   int n_err     = 0;
   int n_overlap = 0;

   // Strobes observed one clock after the last byte sent.
   logic last_load, last_stop, last_err;

   always #5 clock = ~clock;

   alarma_cmd_parser #(
      .TIMEOUT_CYCLES (TO),
      .TO_W           (5)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .load          (load),
      .minute_setare (minute_setare),
      .ore_setare    (ore_setare),
      .stop          (stop),
      .cmd_err       (cmd_err),
      .busy          (busy)
   );

   always @(negedge clock) begin
      if (load)    n_load++;
      if (stop)    n_stop++;
      if (cmd_err) n_err++;
      if ((int'(load) + int'(stop) + int'(cmd_err)) > 1) n_overlap++;
   end

   // Called at negedge+1; byte is taken on the next posedge, response is
   // sampled at the following negedge+1.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      #1;
      rx_valid  = 1'b0;
      last_load = load;
      last_stop = stop;
      last_err  = cmd_err;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i]);
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic test_reset;
      idle(2);
      checks++;
      if ({load, stop, cmd_err, busy, ore_setare, minute_setare} !== 15'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %b want all zero",
                  {load, stop, cmd_err, busy, ore_setare, minute_setare});
      end
      reset = 1'b1;
      idle(1);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_set_spaced;
      int l0, e0;
      l0 = n_load;
      e0 = n_err;
      send_str("A07:45", 2);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL spaced_busy_mid: got %b want 1", busy);
      end
      send_byte(CR);
      checks++;
      if (last_load !== 1'b1) begin
         failures++;
         $display("FAIL spaced_load: got %b want 1", last_load);
      end
      checks++;
      if (ore_setare !== 5'd7 || minute_setare !== 6'd45) begin
         failures++;
         $display("FAIL spaced_value: got %0d:%0d want 7:45", ore_setare, minute_setare);
      end
      idle(2);
      checks++;
      if (n_load - l0 !== 1 || n_err - e0 !== 0) begin
         failures++;
         $display("FAIL spaced_counts: got load=%0d err=%0d want load=1 err=0",
                  n_load - l0, n_err - e0);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL spaced_busy_end: got %b want 0", busy);
      end
   endtask

   task automatic test_back_to_back;
      int l0;
      send_str("a23:59", 0);
      send_byte(CR);
      checks++;
      if (last_load !== 1'b1 || ore_setare !== 5'd23 || minute_setare !== 6'd59) begin
         failures++;
         $display("FAIL b2b_load: got load=%b %0d:%0d want load=1 23:59",
                  last_load, ore_setare, minute_setare);
      end
      l0 = n_load;
      send_str("A24:00", 0);
      send_byte(CR);
      checks++;
      if (last_err !== 1'b1 || last_load !== 1'b0) begin
         failures++;
         $display("FAIL b2b_hour_range: got err=%b load=%b want err=1 load=0",
                  last_err, last_load);
      end
      idle(1);
      checks++;
      if (cmd_err !== 1'b0) begin
         failures++;
         $display("FAIL b2b_err_width: got %b want 0", cmd_err);
      end
      checks++;
      if (n_load - l0 !== 0 || ore_setare !== 5'd23 || minute_setare !== 6'd59) begin
         failures++;
         $display("FAIL b2b_hold: got loads=%0d %0d:%0d want loads=0 23:59",
                  n_load - l0, ore_setare, minute_setare);
      end
   endtask

   task automatic test_bad_colon;
      send_str("A1", 1);
      send_byte("7");
      send_byte(8'h3B);
      checks++;
      if (last_err !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL colon_err: got err=%b busy=%b want err=1 busy=0", last_err, busy);
      end
      send_byte("x");
      send_byte(CR);
      checks++;
      if (last_stop !== 1'b1 || last_err !== 1'b0) begin
         failures++;
         $display("FAIL stop_pulse: got stop=%b err=%b want stop=1 err=0",
                  last_stop, last_err);
      end
      idle(1);
      checks++;
      if (stop !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL stop_after: got stop=%b busy=%b want 0 0", stop, busy);
      end
   endtask

   task automatic test_timeout;
      int e0, first;
      e0    = n_err;
      first = -1;
      send_str("A12:", 0);
      for (int k = 1; k <= 3 * TO; k++) begin
         idle(1);
         if (cmd_err === 1'b1 && first < 0) first = k;
      end
      checks++;
      if (first !== TO) begin
         failures++;
         $display("FAIL timeout_cycle: got %0d want %0d", first, TO);
      end
      checks++;
      if (n_err - e0 !== 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_once: got errs=%0d busy=%b want 1 0", n_err - e0, busy);
      end
      checks++;
      if (ore_setare !== 5'd23 || minute_setare !== 6'd59) begin
         failures++;
         $display("FAIL timeout_hold: got %0d:%0d want 23:59", ore_setare, minute_setare);
      end
      // A byte landing on the expiry cycle must win.
      send_str("A12:", 0);
      idle(TO - 1);
      send_byte("3");
      checks++;
      if (last_err !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL timeout_race: got err=%b busy=%b want 0 1", last_err, busy);
      end
      send_byte("0");
      send_byte(CR);
      checks++;
      if (last_load !== 1'b1 || ore_setare !== 5'd12 || minute_setare !== 6'd30) begin
         failures++;
         $display("FAIL timeout_race_load: got load=%b %0d:%0d want 1 12:30",
                  last_load, ore_setare, minute_setare);
      end
   endtask

   task automatic test_after_timeout;
      send_str("A00:00", 0);
      send_byte(CR);
      checks++;
      if (last_load !== 1'b1 || ore_setare !== 5'd0 || minute_setare !== 6'd0) begin
         failures++;
         $display("FAIL zero_load: got load=%b %0d:%0d want 1 0:0",
                  last_load, ore_setare, minute_setare);
      end
   endtask

   task automatic test_range;
      int l0, s0, e0;
      send_str("A12:6", 0);
      checks++;
      if (last_err !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL min_tens: got err=%b busy=%b want 1 0", last_err, busy);
      end
      send_str("A3", 0);
      checks++;
      if (last_err !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL hour_tens: got err=%b busy=%b want 1 0", last_err, busy);
      end
      idle(1);
      l0 = n_load;
      s0 = n_stop;
      e0 = n_err;
      send_byte(CR);
      send_byte(LF);
      idle(2);
      checks++;
      if (n_load - l0 !== 0 || n_stop - s0 !== 0 || n_err - e0 !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL crlf_idle: got load=%0d stop=%0d err=%0d busy=%b want 0 0 0 0",
                  n_load - l0, n_stop - s0, n_err - e0, busy);
      end
   endtask

   task automatic test_reset_mid;
      int l0;
      send_str("A21:15", 0);
      send_byte(CR);
      checks++;
      if (ore_setare !== 5'd21 || minute_setare !== 6'd15) begin
         failures++;
         $display("FAIL pre_reset_load: got %0d:%0d want 21:15", ore_setare, minute_setare);
      end
      send_str("A09:3", 0);
      reset = 1'b0;
      #1;
      checks++;
      if ({load, stop, cmd_err, busy, ore_setare, minute_setare} !== 15'd0) begin
         failures++;
         $display("FAIL mid_reset_outputs: got %b want all zero",
                  {load, stop, cmd_err, busy, ore_setare, minute_setare});
      end
      idle(1);
      reset = 1'b1;
      idle(1);
      l0 = n_load;
      send_byte("0");
      checks++;
      if (last_err !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_digit: got err=%b want 1", last_err);
      end
      send_byte(CR);
      idle(2);
      checks++;
      if (n_load - l0 !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_noload: got loads=%0d busy=%b want 0 0", n_load - l0, busy);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_set_spaced();
      test_back_to_back();
      test_bad_colon();
      test_timeout();
      test_after_timeout();
      test_range();
      test_reset_mid();
      checks++;
      if (n_overlap !== 0) begin
         failures++;
         $display("FAIL strobe_overlap: got %0d cycles want 0", n_overlap);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
